// File: rtl/l1d_mmu_responder_pkg.sv
// Shared definitions for the L1D MMU responder: FSM encoding, line geometry
// and the MMIO timeout read pattern.
package l1d_mmu_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LRD,
    ST_LWR,
    ST_IO,
    ST_DONE,
    ST_REST
  } mmu_state_e;

  localparam int LINE_BYTES = 32;
  localparam int LINE_BEATS = 8;
  localparam int BEAT_W     = 3;

  localparam logic [31:0] IO_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Cached requests address whole lines; the offset within the line is dropped.
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & ~32'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/l1d_mmu_responder_line_beat_seq.sv
// Beat sequencer for line bursts: issue index runs 0..BEATS-1 from start,
// capture index trails it by one cycle to match the memory read latency.
module line_beat_seq
  import l1d_mmu_responder_pkg::*;
#(
  parameter int BEATS = LINE_BEATS
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              issue_valid,
  output logic [BEAT_W-1:0] issue_idx,
  output logic              capture_valid,
  output logic [BEAT_W-1:0] capture_idx,
  output logic              last_issue,
  output logic              last_capture
);

  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BEATS - 1);

  logic              active_q;
  logic              cap_valid_q;
  logic [BEAT_W-1:0] beat_q;
  logic [BEAT_W-1:0] cap_idx_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= 1'b0;
      beat_q      <= '0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
    end else begin
      cap_valid_q <= active_q;
      cap_idx_q   <= beat_q;
      if (start) begin
        active_q <= 1'b1;
        beat_q   <= '0;
      end else if (active_q) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == LAST) active_q <= 1'b0;
      end
    end
  end

  assign issue_valid   = active_q;
  assign issue_idx     = beat_q;
  assign capture_valid = cap_valid_q;
  assign capture_idx   = cap_idx_q;
  assign last_issue    = active_q && (beat_q == LAST);
  assign last_capture  = cap_valid_q && (cap_idx_q == LAST);

endmodule

// File: rtl/mmio_addr.sv
// Shared MMIO region decoder: flags addresses inside the peripheral window.
module mmio_addr #(
  parameter logic [31:0] MMIO_BASE = 32'hF000_0000,
  parameter logic [31:0] MMIO_MASK = 32'hF000_0000
) (
  input  logic [31:0] addr,
  output logic        is_mmio
);

  assign is_mmio = (addr & MMIO_MASK) == MMIO_BASE;

endmodule

// File: rtl/l1d_mmu_responder.sv
// Memory-side responder for the L1D MMU port: line bursts to word memory,
// single-word MMIO to the peripheral bus. Optional MMU_IO_TIMEOUT_EN adds an IO watchdog.
module l1d_mmu_responder #(
  parameter int LINE_BEATS = 8,
  parameter int IO_TIMEOUT = 255
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         l1_mmu_req_read,
  input  logic         l1_mmu_req_write,
  input  logic [31:0]  l1_mmu_req_addr,
  input  logic [255:0] l1_mmu_write_data,
  output logic         mmu_l1_done,
  output logic [255:0] mmu_l1_read_data,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata,
  output logic         io_req,
  output logic         io_we,
  output logic [31:0]  io_addr,
  output logic [31:0]  io_wdata,
  input  logic         io_ack,
  input  logic [31:0]  io_rdata
);
  import l1d_mmu_responder_pkg::*;

  mmu_state_e state_q, state_d;

  logic              req_is_mmio;
  logic              accept;
  logic              seq_start;
  logic              io_timeout;
  logic [31:0]       addr_q;
  logic              is_write_q;
  logic [255:0]      wline_q;
  logic [255:0]      rbuf_q;

  logic              issue_valid;
  logic [BEAT_W-1:0] issue_idx;
  logic              capture_valid;
  logic [BEAT_W-1:0] capture_idx;
  logic              last_issue;
  logic              last_capture;

  mmio_addr u_mmio_addr (
    .addr    (l1_mmu_req_addr),
    .is_mmio (req_is_mmio)
  );

  assign accept    = (state_q == ST_IDLE) && (l1_mmu_req_read || l1_mmu_req_write);
  assign seq_start = accept && !req_is_mmio;

  line_beat_seq #(
    .BEATS (LINE_BEATS)
  ) u_seq (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .start         (seq_start),
    .issue_valid   (issue_valid),
    .issue_idx     (issue_idx),
    .capture_valid (capture_valid),
    .capture_idx   (capture_idx),
    .last_issue    (last_issue),
    .last_capture  (last_capture)
  );

`ifdef MMU_IO_TIMEOUT_EN
  logic [7:0] io_cnt_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      io_cnt_q <= '0;
    end else if (state_q != ST_IO) begin
      io_cnt_q <= '0;
    end else begin
      io_cnt_q <= io_cnt_q + 8'd1;
    end
  end

  // io_cnt_q equals the number of IO cycles already spent before this one.
  assign io_timeout = (state_q == ST_IO) && !io_ack && (io_cnt_q == 8'(IO_TIMEOUT - 1));
`else
  logic [7:0] unused_io_timeout;
  assign unused_io_timeout = 8'(IO_TIMEOUT);
  assign io_timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (l1_mmu_req_write || l1_mmu_req_read) begin
          if (req_is_mmio)           state_d = ST_IO;
          else if (l1_mmu_req_write) state_d = ST_LWR;
          else                       state_d = ST_LRD;
        end
      end
      ST_LRD:  if (last_capture) state_d = ST_DONE;
      ST_LWR:  if (last_issue) state_d = ST_DONE;
      ST_IO:   if (io_ack || io_timeout) state_d = ST_DONE;
      ST_DONE: state_d = ST_REST;
      ST_REST: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The write latch and the read buffer are separate so write-backs never
  // disturb the read data the cache may still be consuming.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      is_write_q <= 1'b0;
      wline_q    <= '0;
      rbuf_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= req_is_mmio ? l1_mmu_req_addr : line_base(l1_mmu_req_addr);
        is_write_q <= l1_mmu_req_write;
        wline_q    <= l1_mmu_write_data;
      end
      if ((state_q == ST_LRD) && capture_valid) begin
        rbuf_q[{capture_idx, 5'b0} +: 32] <= mem_rdata;
      end
      if ((state_q == ST_IO) && !is_write_q) begin
        if (io_ack)          rbuf_q <= {224'b0, io_rdata};
        else if (io_timeout) rbuf_q <= {224'b0, IO_TIMEOUT_DATA};
      end
    end
  end

  assign mem_rd    = (state_q == ST_LRD) && issue_valid;
  assign mem_wr    = (state_q == ST_LWR) && issue_valid;
  assign mem_addr  = (mem_rd || mem_wr) ? {addr_q[31:5], issue_idx, 2'b00} : 32'h0;
  assign mem_wdata = mem_wr ? wline_q[{issue_idx, 5'b0} +: 32] : 32'h0;

  assign io_req   = (state_q == ST_IO);
  assign io_we    = io_req && is_write_q;
  assign io_addr  = io_req ? addr_q : 32'h0;
  assign io_wdata = io_req ? wline_q[31:0] : 32'h0;

  assign mmu_l1_done      = (state_q == ST_DONE);
  assign mmu_l1_read_data = rbuf_q;

endmodule

// File: tb/tb_l1d_mmu_responder.sv
// Bench for l1d_mmu_responder: vector table of single transactions plus
// hand sequences for flush/fill and reset mid-burst, with a memory model.
`timescale 1ns/1ps
module tb_l1d_mmu_responder;

  logic         sys_clk = 1'b0;
  logic         rst_n;
  logic         l1_mmu_req_read;
  logic         l1_mmu_req_write;
  logic [31:0]  l1_mmu_req_addr;
  logic [255:0] l1_mmu_write_data;
  logic         mmu_l1_done;
  logic [255:0] mmu_l1_read_data;
  logic         mem_rd;
  logic         mem_wr;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         io_req;
  logic         io_we;
  logic [31:0]  io_addr;
  logic [31:0]  io_wdata;
  logic         io_ack;
  logic [31:0]  io_rdata;

  always #5 sys_clk = ~sys_clk;

  l1d_mmu_responder dut (
    .sys_clk           (sys_clk),
    .rst_n             (rst_n),
    .l1_mmu_req_read   (l1_mmu_req_read),
    .l1_mmu_req_write  (l1_mmu_req_write),
    .l1_mmu_req_addr   (l1_mmu_req_addr),
    .l1_mmu_write_data (l1_mmu_write_data),
    .mmu_l1_done       (mmu_l1_done),
    .mmu_l1_read_data  (mmu_l1_read_data),
    .mem_rd            (mem_rd),
    .mem_wr            (mem_wr),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .io_req            (io_req),
    .io_we             (io_we),
    .io_addr           (io_addr),
    .io_wdata          (io_wdata),
    .io_ack            (io_ack),
    .io_rdata          (io_rdata)
  );

  // Synchronous word memory; ref_mem is what the bench believes it holds.
  logic [31:0] mem     [0:16383];
  logic [31:0] ref_mem [0:16383];

  always @(posedge sys_clk) begin
    if (mem_wr) mem[mem_addr[15:2]] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr[15:2]];
  end

  typedef struct packed {
    logic [31:0] cyc;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wline;
    int           ack_dly;
    logic [31:0]  iodata;
    logic         io_to;
    int           exp_done;
  } vec_t;

  beat_t        beat_q[$];
  logic [255:0] exp_q[$];
  logic [255:0] last_rd;
  int           total;
  int           bad;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic is_mmio_addr(input logic [31:0] a);
    return a[31:28] == 4'hF;
  endfunction

  // Queue the beats and the read data a request should produce; c0 is the
  // sampling edge of the request relative to the caller's cycle count.
  task automatic push_expect(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [255:0] wline, input logic [31:0] iodata,
                             input logic io_to, input int c0);
    logic [31:0] base;
    logic [31:0] a;
    base = {addr[31:5], 5'b0};
    if (is_mmio_addr(addr)) begin
      if (!wr) last_rd = {224'b0, (io_to ? 32'hDEAD_BEEF : iodata)};
    end else begin
      for (int b = 0; b < 8; b++) begin
        a = base + 32'(b * 4);
        beat_q.push_back({32'(c0 + b + 1), wr, a, (wr ? wline[b*32 +: 32] : 32'h0)});
        if (wr) ref_mem[a[15:2]] = wline[b*32 +: 32];
        else    last_rd[b*32 +: 32] = ref_mem[a[15:2]];
      end
    end
    exp_q.push_back(last_rd);
  endtask

  task automatic step_cycle(input int c);
    beat_t b;
    if (mem_rd || mem_wr) begin
      if (beat_q.size() == 0) begin
        check("strobe_unexpected", {mem_rd, mem_wr, mem_addr}, '0);
      end else begin
        b = beat_q.pop_front();
        check("beat", {32'(c), mem_rd, mem_wr, mem_addr, (mem_wr ? mem_wdata : 32'h0)},
              {b.cyc, ~b.wr, b.wr, b.addr, b.data});
      end
    end
  endtask

  task automatic on_done(input string name, input int c, input int exp_c);
    check({name, "_done_cycle"}, 512'(c), 512'(exp_c));
    if (exp_q.size() == 0) check({name, "_done_unexpected"}, mmu_l1_done, 1'b0);
    else check({name, "_rdata"}, mmu_l1_read_data, exp_q.pop_front());
  endtask

  task automatic outputs_zero(input string name);
    check(name, {mmu_l1_done, mmu_l1_read_data, mem_rd, mem_wr, mem_addr, mem_wdata,
                 io_req, io_we, io_addr, io_wdata}, '0);
  endtask

  // Entered just after a negedge with the DUT idle; leaves it idle likewise.
  task automatic do_txn(input string name, input vec_t v);
    int done_c;
    push_expect(v.rd, v.wr, v.addr, v.wline, v.iodata, v.io_to, 0);
    l1_mmu_req_read   = v.rd;
    l1_mmu_req_write  = v.wr;
    l1_mmu_req_addr   = v.addr;
    l1_mmu_write_data = v.wline;
    io_rdata          = v.iodata;
    @(posedge sys_clk);
    done_c = -1;
    for (int c = 1; c <= 1100 && done_c < 0; c++) begin
      @(negedge sys_clk);
      io_ack = 1'b0;
      step_cycle(c);
      if (c == 1 && is_mmio_addr(v.addr))
        check({name, "_io_start"}, {io_req, io_we, io_addr, io_wdata},
              {1'b1, v.wr, v.addr, v.wline[31:0]});
      if (mmu_l1_done) begin
        done_c = c;
        on_done(name, c, v.exp_done);
        if (v.io_to) check({name, "_io_dropped"}, io_req, 1'b0);
      end else if (io_req && c == v.ack_dly + 1) begin
        io_ack = 1'b1;
      end
    end
    if (done_c < 0) check({name, "_no_done"}, mmu_l1_done, 1'b1);
    io_ack           = 1'b0;
    l1_mmu_req_read  = 1'b0;
    l1_mmu_req_write = 1'b0;
    @(negedge sys_clk);
    check({name, "_rest"}, {mmu_l1_done, mem_rd, mem_wr, io_req}, '0);
    check({name, "_beats_left"}, 512'(beat_q.size()), '0);
    @(negedge sys_clk);
  endtask

  vec_t         vecs[$];
  logic [255:0] line_a;
  logic [255:0] line_r;
  logic [255:0] line_f;
  int           ndone;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    last_rd = '0;
    rst_n = 1'b0;
    l1_mmu_req_read = 1'b0;
    l1_mmu_req_write = 1'b0;
    l1_mmu_req_addr = '0;
    l1_mmu_write_data = '0;
    io_ack = 1'b0;
    io_rdata = '0;
    for (int i = 0; i < 16384; i++) begin
      mem[i] = {16'hC0DE, 16'(i)};
      ref_mem[i] = {16'hC0DE, 16'(i)};
    end
    for (int k = 0; k < 8; k++) begin
      mem[(32'h1220 >> 2) + k] = 32'(k + 1);
      ref_mem[(32'h1220 >> 2) + k] = 32'(k + 1);
    end
    for (int b = 0; b < 8; b++) begin
      line_a[b*32 +: 32] = 32'hA0 + 32'(b);
      line_r[b*32 +: 32] = $urandom;
      line_f[b*32 +: 32] = 32'h0F0F_0000 + 32'(b);
    end

    vecs.push_back('{rd:1'b1, wr:1'b0, addr:32'h0000_1234, wline:'0, ack_dly:-1, iodata:'0, io_to:1'b0, exp_done:10});
    vecs.push_back('{rd:1'b0, wr:1'b1, addr:32'h0000_8040, wline:line_a, ack_dly:-1, iodata:'0, io_to:1'b0, exp_done:9});
    vecs.push_back('{rd:1'b1, wr:1'b0, addr:32'h0000_8044, wline:'1, ack_dly:-1, iodata:'0, io_to:1'b0, exp_done:10});
    vecs.push_back('{rd:1'b1, wr:1'b1, addr:32'h0000_031C, wline:line_r, ack_dly:-1, iodata:'0, io_to:1'b0, exp_done:9});
    vecs.push_back('{rd:1'b1, wr:1'b0, addr:32'h0000_0300, wline:'0, ack_dly:-1, iodata:'0, io_to:1'b0, exp_done:10});
    vecs.push_back('{rd:1'b1, wr:1'b0, addr:32'hF000_0010, wline:line_f, ack_dly:3, iodata:32'h55, io_to:1'b0, exp_done:5});
    vecs.push_back('{rd:1'b1, wr:1'b1, addr:32'hF000_0020, wline:line_r, ack_dly:3, iodata:32'h77, io_to:1'b0, exp_done:5});
    vecs.push_back('{rd:1'b1, wr:1'b0, addr:32'hF000_0104, wline:'0, ack_dly:0, iodata:32'hCAFE, io_to:1'b0, exp_done:2});
`ifdef MMU_IO_TIMEOUT_EN
    vecs.push_back('{rd:1'b1, wr:1'b0, addr:32'hF000_0200, wline:'0, ack_dly:-1, iodata:32'h1, io_to:1'b1, exp_done:256});
`else
    vecs.push_back('{rd:1'b1, wr:1'b0, addr:32'hF000_0200, wline:'0, ack_dly:1000, iodata:32'h1234, io_to:1'b0, exp_done:1002});
`endif

    #1;
    outputs_zero("reset_outputs");
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);

    for (int i = 0; i < vecs.size(); i++) begin
      do_txn($sformatf("v%0d", i), vecs[i]);
    end
    check("mem_word_8040", mem[32'h8040 >> 2], 32'hA0);
    check("mem_word_805c", mem[32'h805C >> 2], 32'hA7);

    // Flush then fill: the read is raised in the done cycle and held through REST.
    push_expect(1'b0, 1'b1, 32'h0000_0100, line_f, '0, 1'b0, 0);
    push_expect(1'b1, 1'b0, 32'h0000_0200, '0, '0, 1'b0, 11);
    l1_mmu_req_write  = 1'b1;
    l1_mmu_req_addr   = 32'h0000_0100;
    l1_mmu_write_data = line_f;
    @(posedge sys_clk);
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge sys_clk);
      step_cycle(c);
      if (mmu_l1_done) begin
        ndone++;
        if (ndone == 1) begin
          on_done("flush", c, 9);
          l1_mmu_req_write  = 1'b0;
          l1_mmu_req_read   = 1'b1;
          l1_mmu_req_addr   = 32'h0000_0200;
          l1_mmu_write_data = '1;
        end else begin
          on_done("fill", c, 21);
          l1_mmu_req_read = 1'b0;
        end
      end
    end
    check("flush_fill_dones", 512'(ndone), 512'd2);
    check("flush_fill_beats_left", 512'(beat_q.size()), '0);

    // Reset asserted during the beat-4 cycle of a read burst.
    push_expect(1'b1, 1'b0, 32'h0000_1234, '0, '0, 1'b0, 0);
    l1_mmu_req_read = 1'b1;
    l1_mmu_req_addr = 32'h0000_1234;
    @(posedge sys_clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge sys_clk);
      step_cycle(c);
    end
    rst_n = 1'b0;
    #1;
    outputs_zero("midburst_reset_outputs");
    beat_q.delete();
    exp_q.delete();
    last_rd = '0;
    l1_mmu_req_read = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
    do_txn("after_reset", vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1d_mmu_responder.md
# l1d_mmu_responder

Memory-side responder for the L1 data cache's MMU request interface. Accepts cached 32-byte line reads and line write-backs and serves them as 8-beat word bursts against a word-wide synchronous main memory. Forwards MMIO single-word accesses to the peripheral bus. Signals completion to the cache with a one-cycle `mmu_l1_done` pulse.

## Interface
Parameters:
- `LINE_BEATS`, 8: words per cache line; fixed to 32 B / 4 B.
- `IO_TIMEOUT`, 255: cycles to wait for `io_ack`; used only with the macro in Configuration.

Ports:
- `sys_clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `l1_mmu_req_read` in 1: read request, level, held until done.
- `l1_mmu_req_write` in 1: write request, level, held until done.
- `l1_mmu_req_addr` in 32: request address. Bits [4:0] are ignored for cached requests.
- `l1_mmu_write_data` in 256: write-back line; bits [31:0] carry MMIO write data.
- `mmu_l1_done` out 1: one-cycle completion pulse.
- `mmu_l1_read_data` out 256: read line; bits [31:0] carry MMIO read data.
- `mem_rd` out 1: main-memory read strobe.
- `mem_wr` out 1: main-memory write strobe.
- `mem_addr` out 32: byte address, word aligned.
- `mem_wdata` out 32: main-memory write data.
- `mem_rdata` in 32: main-memory read data, valid the cycle after `mem_rd`.
- `io_req` out 1: peripheral request, level.
- `io_we` out 1: peripheral write enable.
- `io_addr` out 32: peripheral address.
- `io_wdata` out 32: peripheral write data.
- `io_ack` in 1: peripheral completion, one cycle.
- `io_rdata` in 32: peripheral read data, valid with `io_ack`.

## Operation
- **MMIO classification:** by the shared `mmio_addr` decoder on `l1_mmu_req_addr`.
- **States:** IDLE, LRD, LWR, IO, DONE, REST.
- **IDLE transitions:**
  - A write request takes priority over a read request.
  - MMIO request → IO.
  - Cached write → LWR.
  - Cached read → LRD.
- **On accept:**
  - Latch the address, with bits [4:0] cleared when cached.
  - Latch `l1_mmu_write_data` into the 256-bit line buffer.
- **LWR:**
  - Issue beats 0..7 on consecutive cycles.
  - `mem_wr`=1, `mem_addr` = {line, beat[2:0], 2'b00}, `mem_wdata` = buffer word[beat].
  - Beat 0 is bits [31:0].
  - → DONE after beat 7.
- **LRD:**
  - Issue `mem_rd` beats 0..7 the same way.
  - Capture `mem_rdata` one cycle later into buffer word[beat].
  - → DONE after the beat-7 capture.
- **IO:**
  - Hold `io_req`=1 with `io_we`, `io_addr` and `io_wdata` = write data [31:0].
  - On `io_ack`: for a read, load {224'b0, `io_rdata`} into the buffer; → DONE.
- **DONE:**
  - `mmu_l1_done`=1 for exactly one cycle.
  - `mmu_l1_read_data` is valid in this cycle. → REST.
- **REST:** one cycle during which requests are ignored, so the cache can update its tags and drop or change its request. → IDLE.
- **Read-data hold:** `mmu_l1_read_data` is driven from the buffer and holds its value until the next read or MMIO read captures data. Write transactions must not alter the buffer's exposed value; a dedicated read buffer is separate from the write latch.
- **Request dropped mid-transaction:** the transaction completes anyway.
- **Reset values:** reset may be asserted mid-burst. All outputs are then 0, state is IDLE, beat counter 0, buffers 0.

## Timing
Cycle 0 is the edge at which IDLE samples the request.
- **Cached write:**
  - `mem_wr` is high in cycles 1–8.
  - `mmu_l1_done` is high in cycle 9.
  - The next request is accepted at the earliest at edge 11.
- **Cached read:**
  - `mem_rd` is high in cycles 1–8.
  - Captures occur at the end of cycles 2–9.
  - `mmu_l1_done` is high in cycle 10.
- **MMIO:**
  - `io_req` rises in cycle 1.
  - `mmu_l1_done` is high the cycle after the `io_ack` cycle.
- **Dirty flush:** the write completes, then the read.

## Configuration
- `MMU_IO_TIMEOUT_EN`:
  - **Defined:** an 8-bit counter runs in IO. After `IO_TIMEOUT` cycles without `io_ack`, the block drops `io_req`, sets read data to {224'b0, 32'hDEAD_BEEF} for reads, and → DONE.
  - **Undefined:** IO waits indefinitely and no counter exists.

## Structure
- **Shared package:**
  - State encoding.
  - `LINE_BYTES`=32, `LINE_BEATS`=8, `BEAT_W`=3.
  - MMIO timeout pattern 32'hDEAD_BEEF.
- **Sub-module `line_beat_seq`:**
  - Contains the beat counter and issue/capture indices, with capture delayed one cycle.
  - Outputs the `last_issue` and `last_capture` flags.
- **Reused:** the existing `mmio_addr` decoder is instantiated unchanged.

## Test plan
- **Cached read:** read at 0x0000_1234 with memory words 0x1220..0x123C = k+1. Expect `mem_addr` 0x1220..0x123C in cycles 1–8, done in cycle 10, and `mmu_l1_read_data` = {32'd8,…,32'd1}.
- **Cached write:** write at 0x0000_8040 with line {32'hA7..32'hA0}. Expect 8 `mem_wr` beats, word 0x8040 = 0xA0 and word 0x805C = 0xA7, and done in cycle 9.
- **Flush then fill:** write 0x100 followed by read 0x200 with the read held during REST. Expect exactly two done pulses, the read starting at edge 11, and the read data unaffected by the write line.
- **MMIO read:** `io_ack` after 3 cycles with `io_rdata` 0x55. Expect `mmu_l1_read_data[31:0]`=0x55 and done in cycle 5. Simultaneous read and write requests: the write wins.
- **Reset mid-burst:** `rst_n` low during the beat-4 cycle. Expect all outputs 0 immediately, and a new read after release to behave as a clean cycle-0 start.
- **Timeout:** with `MMU_IO_TIMEOUT_EN` and no ack, expect done after 255 cycles with 0xDEADBEEF. Without the macro, expect no done after 1000 cycles.
